// File: rtl/draw_scheduler_pkg.sv
// Shared constants, colours and state encoding for the Connect Four draw scheduler.
package draw_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] BLACK  = 3'b000;

  localparam int GRID_LEN  = 2;
  localparam int BLOCK_LEN = 4;
  localparam int PITCH     = BLOCK_LEN + GRID_LEN;
  localparam int NUM_COLS  = 7;
  localparam int NUM_ROWS  = 6;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DROP,
    PTR_ERASE,
    PTR_DRAW,
    ACK
  } state_t;

  // Remembers which requester owns the current transaction so ACK pulses the right line.
  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_CLR,
    GRANT_DROP,
    GRANT_PTR
  } grant_t;

  function automatic logic [2:0] player_colour(input logic player);
    return player ? YELLOW : RED;
  endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Requester handshakes plus the pixel-plot port of the VGA adapter.
interface draw_scheduler_if;

  logic       clr_req;
  logic       clr_ack;
  logic       drop_req;
  logic [2:0] drop_col;
  logic [2:0] drop_row;
  logic       drop_player;
  logic       drop_ack;
  logic       ptr_req;
  logic [2:0] ptr_col;
  logic       ptr_player;
  logic       ptr_ack;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  // The requesters and the adapter together form the master side.
  modport master (
    output clr_req, drop_req, drop_col, drop_row, drop_player,
           ptr_req, ptr_col, ptr_player,
    input  clr_ack, drop_ack, ptr_ack, x, y, colour, plot
  );

  // The scheduler itself.
  modport slave (
    input  clr_req, drop_req, drop_col, drop_row, drop_player,
           ptr_req, ptr_col, ptr_player,
    output clr_ack, drop_ack, ptr_ack, x, y, colour, plot
  );

endinterface

// File: rtl/draw_scheduler_cell_addr.sv
// Maps a cell (or the pointer strip) and a pixel index inside its 4x4 block to screen x/y.
module cell_addr
  import draw_pkg::*;
#(
  parameter int unsigned BOARD_X0  = 2,
  parameter int unsigned BOARD_Y0  = 2,
  parameter int unsigned POINTER_Y = 40
) (
  input  logic [2:0] col,
  input  logic [2:0] row,
  input  logic       ptr_sel,
  input  logic [3:0] pix,
  output logic [7:0] x,
  output logic [6:0] y
);

  // Row 0 is the bottom of the board, so board y counts down from the top row.
  always_comb begin
    x = 8'(BOARD_X0) + 8'(col) * 8'(PITCH) + 8'(pix[1:0]);
    if (ptr_sel) begin
      y = 7'(POINTER_Y) + 7'(pix[3:2]);
    end else begin
      y = 7'(BOARD_Y0) + 7'(3'(NUM_ROWS - 1) - row) * 7'(PITCH) + 7'(pix[3:2]);
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Arbitrates clear/drop/pointer requests onto the single pixel-plot port, one pixel per cycle.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int unsigned BOARD_X0  = 2,
  parameter int unsigned BOARD_Y0  = 2,
  parameter int unsigned POINTER_Y = 40
) (
  input logic            clk,
  input logic            resetn,
  draw_scheduler_if.slave bus
);

  state_t     state;
  grant_t     grant;
  logic [3:0] pix;
  logic [2:0] cell_col;
  logic [2:0] cell_row;
  logic [2:0] ptr_old;
  logic [2:0] op_col;
  logic [2:0] op_row;
  logic       op_player;

  logic       drop_ok;
  logic       ptr_ok;
  logic [2:0] sel_col;
  logic [2:0] sel_row;
  logic       sel_ptr;
  logic [7:0] addr_x;
  logic [6:0] addr_y;
  logic       drawing;
  logic [2:0] pix_colour;

  assign drop_ok = (bus.drop_col <= 3'(NUM_COLS - 1)) && (bus.drop_row <= 3'(NUM_ROWS - 1));
  assign ptr_ok  = (bus.ptr_col <= 3'(NUM_COLS - 1));

  // Main FSM: arbitrate in IDLE, latch operands on grant, walk pixel/cell counters while drawing.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      grant     <= GRANT_NONE;
      pix       <= '0;
      cell_col  <= '0;
      cell_row  <= '0;
      ptr_old   <= 3'd3;
      op_col    <= '0;
      op_row    <= '0;
      op_player <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          pix <= '0;
          if (bus.clr_req) begin
            grant    <= GRANT_CLR;
            cell_col <= '0;
            cell_row <= '0;
            state    <= CLEAR;
          end else if (bus.drop_req) begin
            grant     <= GRANT_DROP;
            op_col    <= bus.drop_col;
            op_row    <= bus.drop_row;
            op_player <= bus.drop_player;
            state     <= drop_ok ? DROP : ACK;
          end else if (bus.ptr_req) begin
            grant     <= GRANT_PTR;
            op_col    <= bus.ptr_col;
            op_row    <= '0;
            op_player <= bus.ptr_player;
            state     <= ptr_ok ? PTR_ERASE : ACK;
          end
        end
        CLEAR: begin
          pix <= pix + 4'd1;
          if (pix == 4'hF) begin
            if (cell_col == 3'(NUM_COLS - 1)) begin
              cell_col <= '0;
              if (cell_row == 3'(NUM_ROWS - 1)) begin
                cell_row <= '0;
                state    <= ACK;
              end else begin
                cell_row <= cell_row + 3'd1;
              end
            end else begin
              cell_col <= cell_col + 3'd1;
            end
          end
        end
        DROP: begin
          pix <= pix + 4'd1;
          if (pix == 4'hF) state <= ACK;
        end
        PTR_ERASE: begin
          pix <= pix + 4'd1;
          if (pix == 4'hF) state <= PTR_DRAW;
        end
        PTR_DRAW: begin
          pix <= pix + 4'd1;
          if (pix == 4'hF) begin
            ptr_old <= op_col;
            state   <= ACK;
          end
        end
        ACK: begin
          grant <= GRANT_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pick which cell the shared address generator looks at in the current state.
  always_comb begin
    sel_col = op_col;
    sel_row = op_row;
    sel_ptr = 1'b0;
    case (state)
      CLEAR: begin
        sel_col = cell_col;
        sel_row = cell_row;
      end
      PTR_ERASE: begin
        sel_col = ptr_old;
        sel_ptr = 1'b1;
      end
      PTR_DRAW: sel_ptr = 1'b1;
      default: ;
    endcase
  end

  cell_addr #(
    .BOARD_X0 (BOARD_X0),
    .BOARD_Y0 (BOARD_Y0),
    .POINTER_Y(POINTER_Y)
  ) u_cell_addr (
    .col    (sel_col),
    .row    (sel_row),
    .ptr_sel(sel_ptr),
    .pix    (pix),
    .x      (addr_x),
    .y      (addr_y)
  );

  // Outputs are a pure decode of registered state, so no input reaches them combinationally.
  always_comb begin
    drawing    = (state == CLEAR) || (state == DROP) || (state == PTR_ERASE) || (state == PTR_DRAW);
    pix_colour = BLACK;
    if ((state == DROP) || (state == PTR_DRAW)) pix_colour = player_colour(op_player);
  end

  assign bus.plot     = drawing;
  assign bus.x        = drawing ? addr_x : '0;
  assign bus.y        = drawing ? addr_y : '0;
  assign bus.colour   = drawing ? pix_colour : BLACK;
  assign bus.clr_ack  = (state == ACK) && (grant == GRANT_CLR);
  assign bus.drop_ack = (state == ACK) && (grant == GRANT_DROP);
  assign bus.ptr_ack  = (state == ACK) && (grant == GRANT_PTR);

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: directed test-plan steps followed by random request mixes,
// compared cycle by cycle against a queue of expected plot/ack cycles built from the board geometry.
module tb_draw_scheduler;

  logic clk;
  logic resetn;

  draw_scheduler_if bus ();

  draw_scheduler #(
    .BOARD_X0 (2),
    .BOARD_Y0 (2),
    .POINTER_Y(40)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic [2:0] acks;  // {clr, drop, ptr}
  } cyc_t;

  cyc_t exp_q[$];
  int   model_ptr = 3;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [2:0] model_colour(input bit player);
    return player ? 3'b110 : 3'b100;
  endfunction

  // A 4x4 block at top-left (x0, y0), px varying fastest.
  function automatic void push_block(input int x0, input int y0, input logic [2:0] c);
    cyc_t e;
    for (int py = 0; py < 4; py++) begin
      for (int px = 0; px < 4; px++) begin
        e.plot = 1'b1;
        e.x = 8'(x0 + px);
        e.y = 7'(y0 + py);
        e.colour = c;
        e.acks = 3'b000;
        exp_q.push_back(e);
      end
    end
  endfunction

  // One ack cycle followed by the mandatory idle cycle.
  function automatic void push_ack(input logic [2:0] a);
    cyc_t e;
    e.plot = 1'b0;
    e.x = '0;
    e.y = '0;
    e.colour = '0;
    e.acks = a;
    exp_q.push_back(e);
    e.acks = 3'b000;
    exp_q.push_back(e);
  endfunction

  function automatic void model_txn(input int kind, input int col, input int row, input bit player);
    if (kind == 0) begin
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 7; c++)
          push_block(2 + c * 6, 2 + (5 - r) * 6, 3'b000);
      push_ack(3'b100);
    end else if (kind == 1) begin
      if (col <= 6 && row <= 5) push_block(2 + col * 6, 2 + (5 - row) * 6, model_colour(player));
      push_ack(3'b010);
    end else begin
      if (col <= 6) begin
        push_block(2 + model_ptr * 6, 40, 3'b000);
        push_block(2 + col * 6, 40, model_colour(player));
        model_ptr = col;
      end
      push_ack(3'b001);
    end
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive a set of simultaneous requests and record the expected cycles in priority order.
  task automatic apply_stimulus(input bit c, input bit d, input bit p,
                                input logic [2:0] dcol, input logic [2:0] drow, input bit dpl,
                                input logic [2:0] pcol, input bit ppl);
    @(negedge clk);
    bus.drop_col    = dcol;
    bus.drop_row    = drow;
    bus.drop_player = dpl;
    bus.ptr_col     = pcol;
    bus.ptr_player  = ppl;
    bus.clr_req     = c;
    bus.drop_req    = d;
    bus.ptr_req     = p;
    if (c) model_txn(0, 0, 0, 1'b0);
    if (d) model_txn(1, int'(dcol), int'(drow), dpl);
    if (p) model_txn(2, int'(pcol), 0, ppl);
  endtask

  // Walk the expected queue one cycle at a time; optionally stop early or disturb operands.
  task automatic check_stream(input int limit, input int mutate_at, input int mutate_kind);
    cyc_t e;
    int n;
    n = 0;
    while (exp_q.size() > 0 && (limit < 0 || n < limit)) begin
      e = exp_q.pop_front();
      @(negedge clk);
      check_output("plot", 32'(bus.plot), 32'(e.plot));
      if (e.plot) begin
        check_output("x", 32'(bus.x), 32'(e.x));
        check_output("y", 32'(bus.y), 32'(e.y));
        check_output("colour", 32'(bus.colour), 32'(e.colour));
      end
      check_output("acks", 32'({bus.clr_ack, bus.drop_ack, bus.ptr_ack}), 32'(e.acks));
      if (e.acks[2]) bus.clr_req = 1'b0;
      if (e.acks[1]) bus.drop_req = 1'b0;
      if (e.acks[0]) bus.ptr_req = 1'b0;
      if (n == mutate_at && mutate_kind == 1) begin
        bus.drop_col    = 3'd4;
        bus.drop_row    = bus.drop_row + 3'd1;
        bus.drop_player = ~bus.drop_player;
      end
      if (n == mutate_at && mutate_kind == 2) begin
        bus.ptr_col    = bus.ptr_col + 3'd1;
        bus.ptr_player = ~bus.ptr_player;
      end
      n++;
    end
    exp_q.delete();
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    check_output({tag, "_plot"}, 32'(bus.plot), 32'd0);
    check_output({tag, "_acks"}, 32'({bus.clr_ack, bus.drop_ack, bus.ptr_ack}), 32'd0);
    check_output({tag, "_x"}, 32'(bus.x), 32'd0);
    check_output({tag, "_y"}, 32'(bus.y), 32'd0);
    check_output({tag, "_colour"}, 32'(bus.colour), 32'd0);
  endtask

  initial begin
    bit rc, rd, rp;
    int mk;
    resetn          = 1'b0;
    bus.clr_req     = 1'b0;
    bus.drop_req    = 1'b0;
    bus.drop_col    = '0;
    bus.drop_row    = '0;
    bus.drop_player = 1'b0;
    bus.ptr_req     = 1'b0;
    bus.ptr_col     = '0;
    bus.ptr_player  = 1'b0;

    repeat (3) @(posedge clk);
    check_quiet("reset");
    resetn = 1'b1;
    check_quiet("post_reset");

    $display("[TB] drop col 3 row 0 yellow");
    apply_stimulus(0, 1, 0, 3'd3, 3'd0, 1'b1, 3'd0, 1'b0);
    check_stream(-1, -1, 0);

    $display("[TB] pointer to column 5 from reset position");
    @(negedge clk);
    resetn = 1'b0;
    model_ptr = 3;
    @(negedge clk);
    resetn = 1'b1;
    apply_stimulus(0, 0, 1, 3'd0, 3'd0, 1'b0, 3'd5, 1'b0);
    check_stream(-1, -1, 0);

    $display("[TB] pointer to the column it already occupies");
    apply_stimulus(0, 0, 1, 3'd0, 3'd0, 1'b0, 3'd5, 1'b1);
    check_stream(-1, -1, 0);

    $display("[TB] clear, drop and pointer requested together");
    apply_stimulus(1, 1, 1, 3'd6, 3'd5, 1'b0, 3'd0, 1'b1);
    check_stream(-1, -1, 0);

    $display("[TB] invalid drop column and invalid pointer column");
    apply_stimulus(0, 1, 0, 3'd7, 3'd0, 1'b0, 3'd0, 1'b0);
    check_stream(-1, -1, 0);
    apply_stimulus(0, 0, 1, 3'd0, 3'd0, 1'b0, 3'd7, 1'b1);
    check_stream(-1, -1, 0);

    $display("[TB] reset in the middle of a clear");
    apply_stimulus(1, 0, 0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    check_stream(300, -1, 0);
    @(negedge clk);
    resetn = 1'b0;
    bus.clr_req = 1'b0;
    model_ptr = 3;
    check_quiet("mid_reset");
    resetn = 1'b1;
    check_quiet("after_abort");
    apply_stimulus(0, 1, 0, 3'd1, 3'd4, 1'b0, 3'd0, 1'b0);
    check_stream(-1, -1, 0);

    $display("[TB] drop operands changed while drawing");
    apply_stimulus(0, 1, 0, 3'd2, 3'd1, 1'b0, 3'd0, 1'b0);
    check_stream(-1, 5, 1);

    $display("[TB] random request mixes");
    for (int i = 0; i < 30; i++) begin
      rc = ($urandom_range(0, 11) == 0);
      rd = 1'($urandom_range(0, 1));
      rp = 1'($urandom_range(0, 1));
      if (!rc && !rd && !rp) rd = 1'b1;
      mk = 0;
      if (!rc && rd) mk = 1;
      else if (!rc && rp) mk = 2;
      apply_stimulus(rc, rd, rp,
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                     3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      check_stream(-1, int'($urandom_range(0, 20)), mk);
    end

    check_quiet("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
